mc_ctrl_fsm: RTL and testbench

//  Multi-cycle main control unit. Sequences the PC/NPC datapath, IR, register file,
//  ALU and data memory through FETCH/DECODE/EXECUTE/MEM/WB phases, one instruction
//  at a time. Drives NPC's nPC_sel/j/jr and the PC write enable. Handshakes with

---
 rtl/mc_ctrl_fsm_pkg.sv | 91 +++++++++
 rtl/mc_ctrl_fsm_dec.sv | 93 +++++++++
 rtl/mc_ctrl_fsm.sv | 117 +++++++++++
 tb/tb_mc_ctrl_fsm.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle control unit: states, opcodes, functs and
// control-field codes, plus the DECODE dispatch helper.
package mc_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StExeR   = 4'd3,
    StWbR    = 4'd4,
    StExeI   = 4'd5,
    StWbI    = 4'd6,
    StMemAdr = 4'd7,
    StMemRd  = 4'd8,
    StMemWr  = 4'd9,
    StWbMem  = 4'd10,
    StBr     = 4'd11,
    StJmp    = 4'd12,
    StJr     = 4'd13,
    StJal    = 4'd14
  } state_e;

  localparam logic [5:0] OpRtype   = 6'b000000;
  localparam logic [5:0] OpOri     = 6'b001101;
  localparam logic [5:0] OpLui     = 6'b001111;
  localparam logic [5:0] OpLw      = 6'b100011;
  localparam logic [5:0] OpSw      = 6'b101011;
  localparam logic [5:0] OpBeq     = 6'b000100;
  localparam logic [5:0] OpJ       = 6'b000010;
  localparam logic [5:0] OpJal     = 6'b000011;

  localparam logic [5:0] FunctAddu = 6'b100001;
  localparam logic [5:0] FunctSubu = 6'b100011;
  localparam logic [5:0] FunctJr   = 6'b001000;

  localparam logic [2:0] AluAdd    = 3'b000;
  localparam logic [2:0] AluSub    = 3'b001;
  localparam logic [2:0] AluOr     = 3'b010;

  localparam logic [1:0] ExtZero   = 2'b00;
  localparam logic [1:0] ExtSign   = 2'b01;
  localparam logic [1:0] ExtLui    = 2'b10;

  localparam logic [1:0] DstRt     = 2'b00;
  localparam logic [1:0] DstRd     = 2'b01;
  localparam logic [1:0] DstRa     = 2'b10;

  localparam logic [1:0] M2rAlu    = 2'b00;
  localparam logic [1:0] M2rMem    = 2'b01;
  localparam logic [1:0] M2rPc     = 2'b10;

  typedef struct packed {
    logic       pc_wr;
    logic       ir_wr;
    logic       npc_sel;
    logic       j;
    logic       jr;
    logic       reg_wr;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src;
    logic [1:0] ext_op;
    logic [2:0] alu_ctr;
    logic       mem_rd;
    logic       mem_wr;
    logic       instr_done;
  } ctrl_t;

  // Unrecognised op/funct falls back to StFetch, i.e. the instruction is a NOP.
  function automatic state_e decode_next(input logic [5:0] op, input logic [5:0] funct);
    state_e st;
    st = StFetch;
    case (op)
      OpRtype: begin
        if (funct == FunctAddu || funct == FunctSubu) begin
          st = StExeR;
        end else if (funct == FunctJr) begin
          st = StJr;
        end
      end
      OpOri, OpLui: st = StExeI;
      OpLw, OpSw:   st = StMemAdr;
      OpBeq:        st = StBr;
      OpJ:          st = StJmp;
      OpJal:        st = StJal;
      default:      st = StFetch;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_dec.sv
// Combinational control-word decode from the current state, the IR fields and the few
// status inputs that qualify a state's outputs.
module mc_ctrl_fsm_dec
  import mc_ctrl_fsm_pkg::*;
(
  input  state_e     i_state,
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  input  logic       i_abort,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      StFetch: begin
        o_ctrl.ir_wr = 1'b1;
        o_ctrl.pc_wr = 1'b1;
      end
      StDecode: o_ctrl.instr_done = (decode_next(i_op, i_funct) == StFetch);
      StExeR: begin
        o_ctrl.alu_src = 1'b0;
        o_ctrl.alu_ctr = (i_funct == FunctSubu) ? AluSub : AluAdd;
      end
      StWbR: begin
        o_ctrl.reg_wr     = 1'b1;
        o_ctrl.reg_dst    = DstRd;
        o_ctrl.mem_to_reg = M2rAlu;
        o_ctrl.instr_done = 1'b1;
      end
      StExeI: begin
        o_ctrl.alu_src = 1'b1;
        o_ctrl.alu_ctr = AluOr;
        o_ctrl.ext_op  = (i_op == OpLui) ? ExtLui : ExtZero;
      end
      StWbI: begin
        o_ctrl.reg_wr     = 1'b1;
        o_ctrl.reg_dst    = DstRt;
        o_ctrl.mem_to_reg = M2rAlu;
        o_ctrl.instr_done = 1'b1;
      end
      StMemAdr: begin
        o_ctrl.alu_src = 1'b1;
        o_ctrl.ext_op  = ExtSign;
        o_ctrl.alu_ctr = AluAdd;
      end
      StMemRd: begin
        o_ctrl.mem_rd     = 1'b1;
        o_ctrl.instr_done = i_abort;
      end
      StMemWr: begin
        o_ctrl.mem_wr     = 1'b1;
        o_ctrl.instr_done = i_mem_ready | i_abort;
      end
      StWbMem: begin
        o_ctrl.reg_wr     = 1'b1;
        o_ctrl.reg_dst    = DstRt;
        o_ctrl.mem_to_reg = M2rMem;
        o_ctrl.instr_done = 1'b1;
      end
      StBr: begin
        // Not-taken must not load PC again: FETCH already advanced it.
        o_ctrl.alu_src    = 1'b0;
        o_ctrl.alu_ctr    = AluSub;
        o_ctrl.npc_sel    = 1'b1;
        o_ctrl.pc_wr      = i_zero;
        o_ctrl.instr_done = 1'b1;
      end
      StJmp: begin
        o_ctrl.j          = 1'b1;
        o_ctrl.pc_wr      = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      StJr: begin
        o_ctrl.jr         = 1'b1;
        o_ctrl.pc_wr      = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      StJal: begin
        o_ctrl.j          = 1'b1;
        o_ctrl.pc_wr      = 1'b1;
        o_ctrl.reg_wr     = 1'b1;
        o_ctrl.reg_dst    = DstRa;
        o_ctrl.mem_to_reg = M2rPc;
        o_ctrl.instr_done = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle main control unit: state register, next-state logic, memory-wait
// watchdog and sticky memory-error flag. Output decode lives in mc_ctrl_fsm_dec.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned WAIT_W       = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_pc_wr,
  output logic       o_ir_wr,
  output logic       o_npc_sel,
  output logic       o_j,
  output logic       o_jr,
  output logic       o_reg_wr,
  output logic [1:0] o_reg_dst,
  output logic [1:0] o_mem_to_reg,
  output logic       o_alu_src,
  output logic [1:0] o_ext_op,
  output logic [2:0] o_alu_ctr,
  output logic       o_mem_rd,
  output logic       o_mem_wr,
  output logic       o_instr_done,
  output logic       o_mem_err,
  output logic [3:0] o_state
);

  state_e              r_state;
  state_e              w_state_d;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [WAIT_W-1:0]   w_wait_cnt_d;
  logic                r_mem_err;
  logic                w_in_mem;
  logic                w_abort;
  ctrl_t               w_ctrl;

  assign w_in_mem = (r_state == StMemRd) || (r_state == StMemWr);
  // The MEM_WAIT_MAX-th cycle without ready is the last one spent waiting.
  assign w_abort  = w_in_mem && !i_mem_ready &&
                    (r_wait_cnt == WAIT_W'(MEM_WAIT_MAX - 1));

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:   w_state_d = StFetch;
      StFetch:  w_state_d = StDecode;
      StDecode: w_state_d = decode_next(i_op, i_funct);
      StExeR:   w_state_d = StWbR;
      StExeI:   w_state_d = StWbI;
      StMemAdr: w_state_d = (i_op == OpLw) ? StMemRd : StMemWr;
      StMemRd: begin
        if (i_mem_ready) begin
          w_state_d = StWbMem;
        end else if (w_abort) begin
          w_state_d = StFetch;
        end
      end
      StMemWr: begin
        if (i_mem_ready || w_abort) begin
          w_state_d = StFetch;
        end
      end
      StWbR, StWbI, StWbMem, StBr, StJmp, StJr, StJal: w_state_d = StFetch;
      default:  w_state_d = StIdle;
    endcase
  end

  // Counts only while still waiting; any exit from the memory states clears it.
  assign w_wait_cnt_d = (w_in_mem && !i_mem_ready && !w_abort) ? r_wait_cnt + 1'b1 : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_wait_cnt <= w_wait_cnt_d;
      if (w_abort) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  mc_ctrl_fsm_dec u_dec (
    .i_state     (r_state),
    .i_op        (i_op),
    .i_funct     (i_funct),
    .i_zero      (i_zero),
    .i_mem_ready (i_mem_ready),
    .i_abort     (w_abort),
    .o_ctrl      (w_ctrl)
  );

  assign o_pc_wr      = w_ctrl.pc_wr;
  assign o_ir_wr      = w_ctrl.ir_wr;
  assign o_npc_sel    = w_ctrl.npc_sel;
  assign o_j          = w_ctrl.j;
  assign o_jr         = w_ctrl.jr;
  assign o_reg_wr     = w_ctrl.reg_wr;
  assign o_reg_dst    = w_ctrl.reg_dst;
  assign o_mem_to_reg = w_ctrl.mem_to_reg;
  assign o_alu_src    = w_ctrl.alu_src;
  assign o_ext_op     = w_ctrl.ext_op;
  assign o_alu_ctr    = w_ctrl.alu_ctr;
  assign o_mem_rd     = w_ctrl.mem_rd;
  assign o_mem_wr     = w_ctrl.mem_wr;
  assign o_instr_done = w_ctrl.instr_done;
  assign o_mem_err    = r_mem_err;
  assign o_state      = r_state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: an instruction-level model expands each instruction into its
// expected per-cycle control words; one compare process checks the DUT every cycle.
module tb_mc_ctrl_fsm;
  import mc_ctrl_fsm_pkg::*;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic [5:0] op        = 6'd0;
  logic [5:0] funct     = 6'd0;
  logic       zero      = 1'b0;
  logic       mem_ready = 1'b0;

  logic       pc_wr, ir_wr, npc_sel, j, jr, reg_wr, alu_src, mem_rd, mem_wr;
  logic       instr_done, mem_err;
  logic [1:0] reg_dst, mem_to_reg, ext_op;
  logic [2:0] alu_ctr;
  logic [3:0] state;

  mc_ctrl_fsm #(.MEM_WAIT_MAX(15), .WAIT_W(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_op         (op),
    .i_funct      (funct),
    .i_zero       (zero),
    .i_mem_ready  (mem_ready),
    .o_pc_wr      (pc_wr),
    .o_ir_wr      (ir_wr),
    .o_npc_sel    (npc_sel),
    .o_j          (j),
    .o_jr         (jr),
    .o_reg_wr     (reg_wr),
    .o_reg_dst    (reg_dst),
    .o_mem_to_reg (mem_to_reg),
    .o_alu_src    (alu_src),
    .o_ext_op     (ext_op),
    .o_alu_ctr    (alu_ctr),
    .o_mem_rd     (mem_rd),
    .o_mem_wr     (mem_wr),
    .o_instr_done (instr_done),
    .o_mem_err    (mem_err),
    .o_state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        rdy;
    logic [23:0] vec;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_cmp;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Model state for the cycle being built.
  logic [5:0] c_op, c_funct;
  logic       c_zero;
  logic       m_rdy, m_pc_wr, m_ir_wr, m_npc, m_j, m_jr, m_reg_wr, m_src;
  logic       m_mrd, m_mwr, m_done, m_err;
  logic [1:0] m_dst, m_m2r, m_ext;
  logic [2:0] m_ctr;

  function automatic logic [23:0] dut_vec();
    return {state, pc_wr, ir_wr, npc_sel, j, jr, reg_wr, reg_dst, mem_to_reg, alu_src,
            ext_op, alu_ctr, mem_rd, mem_wr, instr_done, mem_err};
  endfunction

  task automatic clr();
    m_rdy = 1'b1; m_pc_wr = 0; m_ir_wr = 0; m_npc = 0; m_j = 0; m_jr = 0; m_reg_wr = 0;
    m_src = 0; m_mrd = 0; m_mwr = 0; m_done = 0; m_dst = 0; m_m2r = 0; m_ext = 0; m_ctr = 0;
  endtask

  task automatic emit(input logic [3:0] st);
    exp_t e;
    e.op = c_op; e.funct = c_funct; e.zero = c_zero; e.rdy = m_rdy;
    e.vec = {st, m_pc_wr, m_ir_wr, m_npc, m_j, m_jr, m_reg_wr, m_dst, m_m2r, m_src,
             m_ext, m_ctr, m_mrd, m_mwr, m_done, m_err};
    exp_q.push_back(e);
  endtask

  // wait_n = cycles with mem_ready low before it rises (>= 15 means never).
  task automatic add_instr(input logic [5:0] iop, input logic [5:0] ifn, input logic iz,
                           input int wait_n);
    logic is_r, addu, subu, isjr, isi, isls, lw, known;
    int   nmem;
    c_op = iop; c_funct = ifn; c_zero = iz;
    is_r  = (iop == 6'h00);
    addu  = is_r && ifn == 6'h21;
    subu  = is_r && ifn == 6'h23;
    isjr  = is_r && ifn == 6'h08;
    isi   = (iop == 6'h0d) || (iop == 6'h0f);
    lw    = (iop == 6'h23);
    isls  = lw || (iop == 6'h2b);
    known = addu || subu || isjr || isi || isls || iop == 6'h04 || iop == 6'h02 ||
            iop == 6'h03;
    clr(); m_pc_wr = 1; m_ir_wr = 1; emit(StFetch);
    clr(); m_done = !known; emit(StDecode);
    if (addu || subu) begin
      clr(); m_ctr = subu ? 3'b001 : 3'b000; emit(StExeR);
      clr(); m_reg_wr = 1; m_dst = 2'b01; m_done = 1; emit(StWbR);
    end else if (isjr) begin
      clr(); m_jr = 1; m_pc_wr = 1; m_done = 1; emit(StJr);
    end else if (isi) begin
      clr(); m_src = 1; m_ctr = 3'b010; m_ext = (iop == 6'h0f) ? 2'b10 : 2'b00;
      emit(StExeI);
      clr(); m_reg_wr = 1; m_done = 1; emit(StWbI);
    end else if (isls) begin
      clr(); m_src = 1; m_ext = 2'b01; emit(StMemAdr);
      nmem = (wait_n < 15) ? wait_n + 1 : 15;
      for (int k = 0; k < nmem; k++) begin
        clr(); m_rdy = (k == wait_n); m_mrd = lw; m_mwr = !lw;
        m_done = (k == nmem - 1) && (!lw || wait_n >= 15);
        emit(lw ? StMemRd : StMemWr);
      end
      if (wait_n >= 15) begin
        m_err = 1'b1;
      end else if (lw) begin
        clr(); m_reg_wr = 1; m_m2r = 2'b01; m_done = 1; emit(StWbMem);
      end
    end else if (iop == 6'h04) begin
      clr(); m_ctr = 3'b001; m_npc = 1; m_pc_wr = iz; m_done = 1; emit(StBr);
    end else if (iop == 6'h02) begin
      clr(); m_j = 1; m_pc_wr = 1; m_done = 1; emit(StJmp);
    end else if (iop == 6'h03) begin
      clr(); m_j = 1; m_pc_wr = 1; m_reg_wr = 1; m_dst = 2'b10; m_m2r = 2'b10; m_done = 1;
      emit(StJal);
    end
  endtask

  task automatic push_idle();
    c_op = 6'd0; c_funct = 6'd0; c_zero = 1'b0;
    clr(); m_rdy = 1'b0; emit(StIdle);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic pin_len(input string name, input int req);
    check(name, 32'(exp_q.size()), 32'(req));
    exp_q.delete();
    m_err = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain timeout: %0d expected cycles left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Apply the inputs belonging to the cycle at the head of the expectation queue.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (exp_q.size() != 0) begin
      op        = exp_q[0].op;
      funct     = exp_q[0].funct;
      zero      = exp_q[0].zero;
      mem_ready = exp_q[0].rdy;
    end
  end

  always @(negedge clk) begin
    if (rst_n && exp_q.size() != 0) begin
      e_cmp = exp_q.pop_front();
      n_tests++;
      if (dut_vec() !== e_cmp.vec) begin
        n_fail++;
        $display("FAIL cycle %0d (op %0h funct %0h): got 0x%06h, expected 0x%06h",
                 cyc, e_cmp.op, e_cmp.funct, dut_vec(), e_cmp.vec);
      end
    end
  end

  initial begin
    m_err = 1'b0;
    // Pin the model's latencies against hand-counted values.
    add_instr(6'h00, 6'h21, 1'b0, 0);  pin_len("addu latency", 4);
    add_instr(6'h23, 6'h00, 1'b0, 3);  pin_len("lw wait3 latency", 8);
    add_instr(6'h2b, 6'h00, 1'b0, 2);  pin_len("sw wait2 latency", 6);
    add_instr(6'h2b, 6'h00, 1'b0, 99); pin_len("sw abort latency", 18);
    add_instr(6'h04, 6'h00, 1'b1, 0);  pin_len("beq latency", 3);
    add_instr(6'h03, 6'h00, 1'b0, 0);  pin_len("jal latency", 3);
    add_instr(6'h3f, 6'h00, 1'b0, 0);  pin_len("nop latency", 2);

    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {8'd0, dut_vec()}, 32'h0);
    check("reset state", {28'd0, state}, 32'h0);

    @(posedge clk);
    #2;
    rst_n = 1'b1;
    push_idle();
    add_instr(6'h00, 6'h21, 1'b0, 0);   // addu
    add_instr(6'h00, 6'h23, 1'b0, 0);   // subu
    add_instr(6'h0d, 6'h00, 1'b0, 0);   // ori
    add_instr(6'h0f, 6'h00, 1'b0, 0);   // lui
    add_instr(6'h23, 6'h00, 1'b0, 0);   // lw, ready at once
    add_instr(6'h23, 6'h00, 1'b0, 3);   // lw, 3 wait cycles
    add_instr(6'h2b, 6'h00, 1'b0, 2);   // sw, 2 wait cycles
    add_instr(6'h2b, 6'h00, 1'b0, 14);  // sw, ready on the last allowed cycle
    add_instr(6'h04, 6'h00, 1'b1, 0);   // beq taken
    add_instr(6'h04, 6'h00, 1'b0, 0);   // beq not taken
    add_instr(6'h02, 6'h00, 1'b0, 0);   // j
    add_instr(6'h03, 6'h00, 1'b0, 0);   // jal
    add_instr(6'h00, 6'h08, 1'b0, 0);   // jr
    add_instr(6'h3f, 6'h00, 1'b0, 0);   // undefined op
    add_instr(6'h00, 6'h3f, 1'b0, 0);   // undefined funct
    add_instr(6'h2b, 6'h00, 1'b0, 99);  // sw, watchdog abort
    add_instr(6'h00, 6'h21, 1'b0, 0);   // addu with mem_err now set
    begin
      int n0;
      n0 = exp_q.size();
      add_instr(6'h23, 6'h00, 1'b0, 5); // lw cut off in its first MEM_RD cycle
      while (exp_q.size() > n0 + 4) void'(exp_q.pop_back());
    end
    drain();

    #1;
    rst_n = 1'b0;
    #1;
    check("mid reset mem_rd", {31'd0, mem_rd}, 32'h0);
    check("mid reset mem_err", {31'd0, mem_err}, 32'h0);
    check("mid reset outputs", {8'd0, dut_vec()}, 32'h0);

    m_err = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    push_idle();
    add_instr(6'h0d, 6'h00, 1'b0, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
